muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS-style datapath. It replaces the single-cycle MULTU ALU path and the fixed LO-only register-file hook. It supports signed and unsigned multiply and divide, plus MTHI and MTLO. Width is parametrised. It runs beside the ALU and uses a start/busy/done handshake, so control logic stalls on MFHI/MFLO while busy.

---
 rtl/muldiv_unit.sv | 100 ++++++++++
 tb/tb_muldiv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide with architectural HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32,
  localparam int CNTW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             state;
  logic [CNTW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     rem;
  logic               is_div, neg_q, neg_r;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rmd;
  logic [WIDTH:0]     sum;
  logic [WIDTH+1:0]   shl, diff;
  logic [2*WIDTH-1:0] prod;
  // Operand magnitudes, one shift-add / restoring step, and final sign correction
  always_comb begin
    sa    = op[0] & srca[WIDTH-1];
    sb    = op[0] & srcb[WIDTH-1];
    mag_a = sa ? -srca : srca;
    mag_b = sb ? -srcb : srcb;
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mcand : {WIDTH{1'b0}}};
    shl   = {rem, acc[WIDTH-1]};
    diff  = shl - {2'b00, mcand};
    prod  = neg_q ? -acc : acc;
    quo   = ~|mcand ? {WIDTH{1'b1}} : neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end
  // Control FSM: accept, iterate WIDTH steps, then fix signs and write HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      rem     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !op[2]) begin
            state   <= RUN;
            busy    <= 1'b1;
            cnt     <= '0;
            divzero <= 1'b0;
            is_div  <= op[1];
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            rem     <= '0;
            mcand   <= op[1] ? mag_b : mag_a;
            acc     <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
          end else if (start && op[2:1] == 2'b10) begin
            if (op[0]) lo <= srca;
            else hi <= srca;
          end
        end
        RUN: begin
          if (is_div) begin
            rem            <= diff[WIDTH+1] ? shl[WIDTH:0] : diff[WIDTH:0];
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~diff[WIDTH+1]};
          end else begin
            acc <= {sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          divzero  <= is_div & ~|mcand;
          {hi, lo} <= is_div ? {rmd, quo} : prod;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors, corner sequences and randomized checks against an arithmetic model
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] srca = '0, srcb = '0;
  logic        busy, done, divzero;
  logic [31:0] hi, lo;
  int n_pass = 0, n_chk = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic d);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    d = 1'b0;
    p = '0;
    if (o == 3'd0) p = {32'b0, a} * {32'b0, b};
    else if (o == 3'd1) p = 64'(sa * sb);
    else if (b == 0) begin
      p = {a, 32'hFFFFFFFF};
      d = 1'b1;
    end else if (o == 3'd2) p = {a % b, a / b};
    else p = {32'(sa % sb), 32'(sa / sb)};
    {h, l} = p;
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int bcyc);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
    bcyc = 0;
    while (!done && bcyc < 100) begin
      if (busy) bcyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int bc;
    logic [31:0] eh, el;
    logic ed;
    logic [2:0] o;
    logic [31:0] a, b;
    vt[0] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[1] = '{3'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vt[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[4] = '{3'd2, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
    vt[5] = '{3'd0, 32'd2,        32'd3,        32'h00000000, 32'h00000006, 1'b0};
    vt[6] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vt[7] = '{3'd3, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vt[8] = '{3'd2, 32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 1'b0};
    vt[9] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_divzero", 64'(divzero), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, bc);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
      chk($sformatf("vec%0d_done", i), 64'(done), 64'd1);
      chk($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'd0);
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vt[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vt[i].lo));
      chk($sformatf("vec%0d_divzero", i), 64'(divzero), 64'(vt[i].dz));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
    end

    start = 1'b1; op = 3'd4; srca = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", 64'(hi), 64'h12345678);
    chk("mthi_done", 64'(done), 64'd0);
    op = 3'd5; srca = 32'hCAFEBABE;
    @(negedge clk);
    chk("mtlo_lo", 64'(lo), 64'hCAFEBABE);
    chk("mtlo_hi_kept", 64'(hi), 64'h12345678);
    chk("mtlo_done", 64'(done), 64'd0);
    chk("mtlo_busy", 64'(busy), 64'd0);
    op = 3'd6; srca = 32'h1;
    @(negedge clk);
    start = 1'b0;
    chk("reserved_hi", 64'(hi), 64'h12345678);
    chk("reserved_lo", 64'(lo), 64'hCAFEBABE);
    chk("reserved_busy", 64'(busy), 64'd0);

    start = 1'b1; op = 3'd0; srca = 32'd5; srcb = 32'd7;
    @(negedge clk);
    op = 3'd5; srca = 32'h1; srcb = 32'd9;
    @(negedge clk);
    start = 1'b0; srca = 32'hDEAD; op = 3'd0;
    chk("ignored_mtlo_lo", 64'(lo), 64'hCAFEBABE);
    bc = 0;
    while (!done && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    chk("ignored_start_lo", 64'(lo), 64'd35);
    chk("ignored_start_hi", 64'(hi), 64'd0);
    chk("ignored_start_done", 64'(done), 64'd1);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 28);
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 28);
      model(o, a, b, eh, el, ed);
      do_op(o, a, b, bc);
      chk($sformatf("rnd%0d_op%0d_%h_%h_busy", i, o, a, b), 64'(bc), 64'd33);
      chk($sformatf("rnd%0d_op%0d_%h_%h", i, o, a, b), {hi, lo}, {eh, el});
      chk($sformatf("rnd%0d_divzero", i), 64'(divzero), 64'(ed));
    end
    @(negedge clk);

    start = 1'b1; op = 3'd0; srca = 32'd9; srcb = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    chk("async_hi", 64'(hi), 64'd0);
    chk("async_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 64'(busy), 64'd0);
    do_op(3'd0, 32'd5, 32'd5, bc);
    chk("post_reset_busy_cycles", 64'(bc), 64'd33);
    chk("post_reset_lo", 64'(lo), 64'd25);
    chk("post_reset_hi", 64'(hi), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
